// File: rtl/ucsbece154a_memresp_pkg.sv
// ---------------------------------------------------------------------------
// ucsbece154a_memresp_pkg
//   Types and constants shared by the wait-state memory responder.
//   - state_t      : 2-bit FSM state encodings (IDLE / WAIT / RESP)
//   - WORD_W       : data word width
//   - CNT_W        : width of the wait-state down-counter
//   - addr_is_bad(): misalignment / out-of-range test for a byte address
// ---------------------------------------------------------------------------
package ucsbece154a_memresp_pkg;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // A byte address is unusable when it is not word aligned or when its
    // word index falls past the end of the array.
    function automatic logic addr_is_bad(input logic [31:0] addr,
                                         input int unsigned depth);
        logic misaligned;
        logic out_of_range;
        misaligned   = (addr[1:0] != 2'b00);
        out_of_range = ({2'b00, addr[31:2]} >= 32'(depth));
        return misaligned || out_of_range;
    endfunction

endpackage

// File: rtl/ucsbece154a_memresp_ram.sv
// ---------------------------------------------------------------------------
// ucsbece154a_memresp_ram
//   DEPTH x 32-bit storage array. Synchronous write, combinational read.
//   Contents are not reset.
//   Ports:
//     clk   - clock, writes occur on its rising edge
//     we    - write enable
//     addr  - word index (shared by read and write)
//     wdata - write data
//     rdata - combinational read data of mem[addr]
// ---------------------------------------------------------------------------
module ucsbece154a_memresp_ram
    import ucsbece154a_memresp_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // The responder samples this into its output register, so the read
    // path never reaches a module output combinationally.
    assign rdata = mem[addr];

endmodule

// File: rtl/ucsbece154a_memresp.sv
// ---------------------------------------------------------------------------
// ucsbece154a_memresp
//   Single-port memory responder with a programmable number of wait states.
//   A request seen in IDLE is captured, held for WAIT_CYCLES cycles, and then
//   answered with a one-cycle ready_o strobe (RESP). Misaligned or
//   out-of-range addresses answer with err_o=1 and rdata_o=0 and never write.
//   Ports:
//     clk      - single clock, rising edge
//     reset    - asynchronous, active-low reset
//     req_i    - request valid (held until ready_o)
//     we_i     - 1 = write, 0 = read
//     addr_i   - byte address
//     wdata_i  - write data
//     ready_o  - one-cycle response strobe (registered)
//     rdata_o  - read data, valid with ready_o (registered, held between reads)
//     err_o    - error flag, valid with ready_o (registered)
// ---------------------------------------------------------------------------
module ucsbece154a_memresp
    import ucsbece154a_memresp_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [31:0]       addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic              ready_o,
    output logic [WORD_W-1:0] rdata_o,
    output logic              err_o
);

    localparam int             AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);
    localparam logic           NO_WAIT = (WAIT_CYCLES == 0);

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              we_reg;
    logic [31:0]       addr_reg;
    logic [WORD_W-1:0] wdata_reg;

    logic              txn_we;
    logic [31:0]       txn_addr;
    logic [WORD_W-1:0] txn_wdata;
    logic              txn_err;
    logic              enter_resp;
    logic              ram_we;
    logic [WORD_W-1:0] ram_rdata;

    // The transaction being completed: with no wait states the RESP entry
    // edge is also the capture edge, so the live inputs are used directly;
    // otherwise only the captured copies matter.
    always_comb begin
        txn_we    = we_reg;
        txn_addr  = addr_reg;
        txn_wdata = wdata_reg;
        if (state_reg == ST_IDLE) begin
            txn_we    = we_i;
            txn_addr  = addr_i;
            txn_wdata = wdata_i;
        end
    end

    assign txn_err = addr_is_bad(txn_addr, DEPTH);

    // "<= 1" rather than "== 1" so a WAIT state with a zero counter cannot
    // stall forever.
    assign enter_resp = ((state_reg == ST_IDLE) && req_i && NO_WAIT) ||
                        ((state_reg == ST_WAIT) && (cnt_reg <= 4'd1));

    // Gating with reset keeps a request presented during reset from
    // slipping a write into the array.
    assign ram_we = enter_resp && txn_we && !txn_err && reset;

    ucsbece154a_memresp_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (txn_addr[AW+1:2]),
        .wdata (txn_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            ready_o   <= 1'b0;
            err_o     <= 1'b0;
            rdata_o   <= '0;
        end else begin
            // Strobes default low; they are raised only on RESP entry.
            ready_o <= 1'b0;
            err_o   <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (req_i) begin
                        we_reg    <= we_i;
                        addr_reg  <= addr_i;
                        wdata_reg <= wdata_i;
                        cnt_reg   <= WAIT_LD;
                        state_reg <= NO_WAIT ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt_reg <= cnt_reg - 4'd1;
                    if (cnt_reg <= 4'd1) begin
                        state_reg <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    cnt_reg   <= '0;
                end
            endcase

            if (enter_resp) begin
                ready_o <= 1'b1;
                err_o   <= txn_err;
                if (txn_err) begin
                    rdata_o <= '0;
                end else if (!txn_we) begin
                    rdata_o <= ram_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_ucsbece154a_memresp.sv
// ---------------------------------------------------------------------------
// tb_ucsbece154a_memresp
//   Two responders share clock, reset and request fields: dut_a has two wait
//   states, dut_b none. Each has its own req line. Expected responses come
//   from a word-addressed reference memory kept per instance.
// ---------------------------------------------------------------------------
module tb_ucsbece154a_memresp;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_a = 1'b0;
    logic        req_b = 1'b0;
    logic        we_in = 1'b0;
    logic [31:0] addr_in = '0;
    logic [31:0] wdata_in = '0;

    logic        ready_a, ready_b;
    logic        err_a, err_b;
    logic [31:0] rdata_a, rdata_b;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] mem_a [int];
    logic [31:0] mem_b [int];
    logic [31:0] last_rd [2];

    always #5 clk = ~clk;

    ucsbece154a_memresp #(.DEPTH(256), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .reset(reset), .req_i(req_a), .we_i(we_in),
        .addr_i(addr_in), .wdata_i(wdata_in),
        .ready_o(ready_a), .rdata_o(rdata_a), .err_o(err_a)
    );

    ucsbece154a_memresp #(.DEPTH(256), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset), .req_i(req_b), .we_i(we_in),
        .addr_i(addr_in), .wdata_i(wdata_in),
        .ready_o(ready_b), .rdata_o(rdata_b), .err_o(err_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input int s);
        return (s == 0) ? ready_a : ready_b;
    endfunction
    function automatic logic erf(input int s);
        return (s == 0) ? err_a : err_b;
    endfunction
    function automatic logic [31:0] rdt(input int s);
        return (s == 0) ? rdata_a : rdata_b;
    endfunction

    function automatic logic has_word(input int s, input int w);
        return (s == 0) ? mem_a.exists(w) : mem_b.exists(w);
    endfunction

    // One request/response. The requester holds req until it sees ready.
    task automatic txn(input int s, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic scramble);
        int          lat;
        int          n;
        int          widx;
        logic        e;
        logic [31:0] exp_rd;
        lat  = (s == 0) ? 2 : 0;
        widx = int'(a >> 2);
        e    = (a % 4 != 0) || (a / 4 >= 256);
        if (e) exp_rd = 32'h0;
        else if (!w) exp_rd = (s == 0) ? mem_a[widx] : mem_b[widx];
        else exp_rd = last_rd[s];
        last_rd[s] = exp_rd;
        if (!e && w) begin
            if (s == 0) mem_a[widx] = d;
            else mem_b[widx] = d;
        end

        we_in = w; addr_in = a; wdata_in = d;
        req_a = (s == 0); req_b = (s == 1);
        @(posedge clk); #1;
        n = 0;
        while (!rdy(s) && n < 20) begin
            if (scramble) begin
                we_in = 1'($urandom); addr_in = $urandom; wdata_in = $urandom;
            end
            @(posedge clk); #1;
            n++;
        end
        req_a = 1'b0; req_b = 1'b0;
        $display("txn dut%0d we=%0d addr=%h wdata=%h -> lat=%0d err=%0d rdata=%h",
                 s, w, a, d, n, erf(s), rdt(s));
        chk("latency", n, lat);
        chk("err", {31'b0, erf(s)}, {31'b0, e});
        chk("rdata", rdt(s), exp_rd);
        @(posedge clk); #1;
        chk("ready_pulse_end", {31'b0, rdy(s)}, 32'h0);
        chk("err_cleared", {31'b0, erf(s)}, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          pos [3];
        int          pulses;
        int          n;
        int          s;
        int          kind;
        logic        w;
        logic [31:0] a;

        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready_a", {31'b0, ready_a}, 32'h0);
        chk("rst_err_a", {31'b0, err_a}, 32'h0);
        chk("rst_rdata_a", rdata_a, 32'h0);
        chk("rst_ready_b", {31'b0, ready_b}, 32'h0);
        chk("rst_err_b", {31'b0, err_b}, 32'h0);
        chk("rst_rdata_b", rdata_b, 32'h0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        // Write then read back with two wait states
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        txn(0, 1'b0, 32'h10, 32'h0, 1'b0);

        // No wait states: preload then read
        txn(1, 1'b1, 32'h40, 32'hCAFEF00D, 1'b0);
        txn(1, 1'b0, 32'h40, 32'h0, 1'b0);

        // Error responses, then unchanged data
        txn(0, 1'b0, 32'h13, 32'h0, 1'b0);
        txn(0, 1'b0, 32'h400, 32'h0, 1'b0);
        txn(0, 1'b1, 32'h401, 32'h55555555, 1'b0);
        txn(0, 1'b0, 32'h10, 32'h0, 1'b0);

        // Inputs toggled during WAIT are ignored
        txn(0, 1'b1, 32'h30, 32'h13572468, 1'b1);
        txn(0, 1'b0, 32'h30, 32'h0, 1'b1);

        // Reset during WAIT aborts the write
        txn(0, 1'b1, 32'h20, 32'h0BADF00D, 1'b0);
        we_in = 1'b1; addr_in = 32'h20; wdata_in = 32'h12345678; req_a = 1'b1;
        @(posedge clk); #1;
        chk("abort_wait_ready", {31'b0, ready_a}, 32'h0);
        @(negedge clk); reset = 1'b0; req_a = 1'b0;
        #1;
        chk("abort_rst_ready", {31'b0, ready_a}, 32'h0);
        chk("abort_rst_rdata", rdata_a, 32'h0);
        chk("abort_rst_rdata_b", rdata_b, 32'h0);
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        @(negedge clk); reset = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            chk("abort_no_ready", {31'b0, ready_a}, 32'h0);
        end
        txn(0, 1'b0, 32'h20, 32'h0, 1'b0);

        // req held continuously: three back-to-back reads
        we_in = 1'b0; addr_in = 32'h10; wdata_in = 32'h0; req_a = 1'b1;
        pulses = 0; n = 0;
        @(posedge clk); #1;
        while (n < 40) begin
            if (ready_a) begin
                pos[pulses] = n;
                chk("hold_rdata", rdata_a, 32'hDEADBEEF);
                pulses++;
                if (pulses == 3) begin
                    req_a = 1'b0;
                    break;
                end
            end
            @(posedge clk); #1;
            n++;
        end
        req_a = 1'b0;
        $display("hold reads: %0d pulses at %0d %0d %0d", pulses, pos[0], pos[1], pos[2]);
        chk("hold_pulses", pulses, 3);
        for (int k = 0; k < 3; k++) begin
            if (k < pulses) chk("hold_pos", pos[k], 2 + k * 4);
        end
        last_rd[0] = 32'hDEADBEEF;
        @(posedge clk); #1;
        chk("hold_ready_end", {31'b0, ready_a}, 32'h0);
        @(posedge clk); #1;

        // Randomized traffic against the reference memories
        for (int i = 0; i < 40; i++) begin
            s    = int'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 9));
            if (kind == 0)
                a = 32'h100 + ($urandom_range(0, 15) << 2) + $urandom_range(1, 3);
            else if (kind == 1)
                a = (32'd256 + $urandom_range(0, 1000)) << 2;
            else
                a = 32'h100 + ($urandom_range(0, 15) << 2);
            w = 1'($urandom_range(0, 1));
            if (!w && kind > 1 && !has_word(s, int'(a >> 2))) w = 1'b1;
            txn(s, w, a, $urandom, kind == 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
